// File: rtl/ternary_accum_pkg.sv
// Shared types and helpers for the ternary accumulate sequencer.
// The state encoding, the adder guard width and the saturating counter step live here.
package ternary_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The adder runs one bit wider than the accumulator so the carry / sign-overflow bit is visible.
  localparam int unsigned ADD_CARRY_BITS = 1;

  function automatic logic [31:0] sat_cnt_add(input logic [31:0] cnt,
                                              input logic [1:0]  inc,
                                              input int unsigned cnt_w);
    logic [32:0] max_v;
    logic [32:0] sum_v;
    max_v = (33'd1 << cnt_w) - 33'd1;
    sum_v = {1'b0, cnt} + {31'd0, inc};
    return (sum_v > max_v) ? max_v[31:0] : sum_v[31:0];
  endfunction

endpackage

// File: rtl/ternary_accum_seq_adder.sv
// Three-input adder used as the shared datapath of the accumulate sequencer.
// Purely combinational; operands arrive already extended to WIDTH.
module ternary_adder #(
  parameter int unsigned WIDTH = 41
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + c;

endmodule

// File: rtl/ternary_accum_seq.sv
// Packet sum sequencer: folds up to two operands per beat into a running accumulator.
// Define TERNARY_ACCUM_SIGNED_EN for two's-complement operands and signed overflow detection.
module ternary_accum_seq
  import ternary_accum_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SUM_WIDTH = 40,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_b_vld,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam int unsigned ADD_W  = SUM_WIDTH + ADD_CARRY_BITS;
  localparam int unsigned OP_PAD = ADD_W - WIDTH;

  state_e               state_q, state_d;
  logic [SUM_WIDTH-1:0] acc_q, acc_d, out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, out_count_q, out_count_d;
  logic                 ovf_q, ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;

  logic                 beat, in_accum;
  logic [WIDTH-1:0]     b_masked;
  logic [SUM_WIDTH-1:0] acc_op;
  logic [CNT_WIDTH-1:0] cnt_base, cnt_new;
  logic [ADD_W-1:0]     acc_ext, a_ext, b_ext, sum_full;
  logic                 step_ovf, ovf_new;

  assign in_accum = (state_q == ACCUM);
  assign beat     = in_valid && (state_q != DONE);
  assign b_masked = in_b & {WIDTH{in_b_vld}};
  // IDLE feeds zero so the first beat of a packet loads instead of adding.
  assign acc_op   = in_accum ? acc_q : '0;

`ifdef TERNARY_ACCUM_SIGNED_EN
  assign acc_ext  = {acc_op[SUM_WIDTH-1], acc_op};
  assign a_ext    = {{OP_PAD{in_a[WIDTH-1]}}, in_a};
  assign b_ext    = {{OP_PAD{b_masked[WIDTH-1]}}, b_masked};
  assign step_ovf = sum_full[ADD_W-1] ^ sum_full[ADD_W-2];
`else
  assign acc_ext  = {1'b0, acc_op};
  assign a_ext    = {{OP_PAD{1'b0}}, in_a};
  assign b_ext    = {{OP_PAD{1'b0}}, b_masked};
  assign step_ovf = sum_full[ADD_W-1];
`endif

  ternary_adder #(
    .WIDTH(ADD_W)
  ) u_adder (
    .a  (acc_ext),
    .b  (a_ext),
    .c  (b_ext),
    .sum(sum_full)
  );

  assign cnt_base = in_accum ? cnt_q : '0;
  assign cnt_new  = CNT_WIDTH'(sat_cnt_add(32'(cnt_base), {1'b0, in_b_vld} + 2'd1, CNT_WIDTH));
  assign ovf_new  = (in_accum && ovf_q) || step_ovf;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          if (in_last) begin
            out_sum_d   = sum_full[SUM_WIDTH-1:0];
            out_count_d = cnt_new;
            out_ovf_d   = ovf_new;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            acc_d   = sum_full[SUM_WIDTH-1:0];
            cnt_d   = cnt_new;
            ovf_d   = ovf_new;
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ternary_accum_seq.sv
// Directed bench for ternary_accum_seq with a scoreboard of expected packet results.
// Honours TERNARY_ACCUM_SIGNED_EN when the design is built with it.
module tb_ternary_accum_seq;

  localparam int W  = 32;
  localparam int SW = 40;
  localparam int CW = 16;
`ifdef TERNARY_ACCUM_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_b_vld, in_last;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid, out_ready, out_ovf;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  ternary_accum_seq #(
    .WIDTH(W), .SUM_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_b_vld(in_b_vld), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  exp_t   sb[$];
  int     passed = 0;
  int     fails  = 0;
  int     total  = 0;
  longint m_total;
  int     m_cnt;
  bit     m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint ext(input logic [W-1:0] v);
    if (SIGNED) return longint'($signed(v));
    return longint'({32'd0, v});
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic bv, input logic last);
    exp_t e;
    m_total = m_total + ext(a) + (bv ? ext(b) : 64'sd0);
    m_cnt   = (m_cnt + 1 + int'(bv) > 65535) ? 65535 : m_cnt + 1 + int'(bv);
    if (SIGNED) begin
      if (m_total > (longint'(1) << (SW-1)) - 1 || m_total < -(longint'(1) << (SW-1))) m_ovf = 1'b1;
    end else begin
      if (m_total > (longint'(1) << SW) - 1) m_ovf = 1'b1;
    end
    if (last) begin
      e.sum = SW'(m_total);
      e.cnt = CW'(m_cnt);
      e.ovf = m_ovf;
      sb.push_back(e);
      model_reset();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic bv, input logic last);
    int   n;
    logic took;
    n = 0;
    in_a = a; in_b = b; in_b_vld = bv; in_last = last; in_valid = 1'b1;
    do begin
      took = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 50);
    in_valid = 1'b0;
    if (!took) chk("accept_timeout", {63'd0, took}, 64'd1);
    else begin
      model_beat(a, b, bv, last);
      if (last) chk("latency_valid", {63'd0, out_valid}, 64'd1);
    end
  endtask

  task automatic check_result(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid || sb.size() == 0) begin
      chk("result_timeout", {63'd0, out_valid}, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("sum", 64'(out_sum), 64'(e.sum));
    chk("count", 64'(out_count), 64'(e.cnt));
    chk("ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
    chk("in_ready_done", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_sum", 64'(out_sum), 64'(e.sum));
      chk("hold_count", 64'(out_count), 64'(e.cnt));
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", {63'd0, out_valid}, 64'd0);
    chk("post_hs_sum", 64'(out_sum), 64'(e.sum));
    chk("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    exp_t e1;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_b_vld = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single-beat packet: 5 + 7
    send_beat(32'd5, 32'd7, 1'b1, 1'b1);
    check_result(0);

    // Three beats with gaps, b ignored on beat 2
    send_beat(32'd1, 32'd2, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #0;
    send_beat(32'd3, 32'd99, 1'b0, 1'b0);
    @(posedge clk); #1;
    send_beat(32'd10, 32'd20, 1'b1, 1'b1);
    check_result(0);

    // 130 beats of all-ones operands
    for (int i = 0; i < 130; i++)
      send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, i == 129);
    check_result(1);

    // Backpressure with a pending beat offered during DONE
    send_beat(32'd9, 32'd1, 1'b1, 1'b1);
    e1 = sb.pop_front();
    in_a = 32'd2; in_b = 32'd3; in_b_vld = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_sum", 64'(out_sum), 64'(e1.sum));
      chk("bp_count", 64'(out_count), 64'(e1.cnt));
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_hs_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_hs_sum", 64'(out_sum), 64'(e1.sum));
    chk("bp_hs_in_ready", {63'd0, in_ready}, 64'd1);
    model_beat(32'd2, 32'd3, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_result(0);

    // Reset in the middle of a packet
    send_beat(32'd100, 32'd200, 1'b1, 1'b0);
    send_beat(32'd300, 32'd400, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    send_beat(32'd4, 32'd4, 1'b1, 1'b1);
    check_result(0);

    // Counter saturation
    for (int i = 0; i < 32770; i++)
      send_beat(32'd1, 32'd0, 1'b1, i == 32769);
    check_result(0);

`ifdef TERNARY_ACCUM_SIGNED_EN
    send_beat(-32'sd3, 32'sd1, 1'b1, 1'b0);
    send_beat(-32'sd5, 32'd0, 1'b0, 1'b1);
    check_result(0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
